// File: rtl/sram_to_sram_like_bridge_if.sv
// SRAM-like bus between the bridge and the AXI interface.
// The bridge is the master: it issues req and consumes addr_ok/data_ok.
interface sram_to_sram_like_bridge_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_to_sram_like_bridge.sv
// CPU SRAM port to SRAM-like req/addr_ok/data_ok bridge.
// Handles byte-strobe writes, kseg mapping and flush cancel.
module sram_to_sram_like_bridge #(
  parameter int DATA_W   = 32,
  parameter int WRITE_EN = 1,
  parameter int MAP_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sram_en,
  input  logic [DATA_W/8-1:0] sram_wen,
  input  logic [31:0]         sram_addr_v,
  input  logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W-1:0]   sram_rdata,
  output logic                stall,
  input  logic                longest_stall,
  input  logic                cancel,
  sram_to_sram_like_bridge_if.master bus
);

  localparam int SB_W = DATA_W / 8;
  localparam int LO_W = $clog2(SB_W);
  localparam logic [1:0] SZ_FULL = 2'(LO_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_wr;
  logic              w_go;
  logic              w_req;
  logic              w_stall;
  logic              w_cap;
  logic [3:0]        w_cnt;
  logic [LO_W-1:0]   w_lane;
  logic [1:0]        w_size;
  logic [31:0]       w_pa;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] r_rdata;

  assign w_wr = (WRITE_EN != 0) && (|sram_wen);
  assign w_go = sram_en & ~cancel;

  // lowest set strobe gives the lane, popcount gives the size
  always_comb begin
    w_cnt  = '0;
    w_lane = '0;
    for (int i = SB_W - 1; i >= 0; i--) begin
      if (sram_wen[i]) begin
        w_cnt  = w_cnt + 4'd1;
        w_lane = LO_W'(i);
      end
    end
  end

  always_comb begin
    w_size = SZ_FULL;
    if (w_wr) begin
      case (w_cnt)
        4'd1:    w_size = 2'd0;
        4'd2:    w_size = 2'd1;
        4'd4:    w_size = 2'd2;
        default: w_size = SZ_FULL;
      endcase
    end
  end

  always_comb begin
    w_pa = sram_addr_v;
    if ((MAP_EN != 0) && (sram_addr_v[31:30] == 2'b10))
      w_pa = {3'b000, sram_addr_v[28:0]};
    w_addr = w_pa;
    w_addr[LO_W-1:0] = w_wr ? w_lane : '0;
  end

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_cap   = 1'b0;
    unique case (r_state)
      S_IDLE, S_ADDR: begin
        w_req   = w_go;
        w_stall = w_go;
        if (!w_go) begin
          w_next = S_IDLE;
        end else if (bus.addr_ok && bus.data_ok) begin
          w_next = S_DONE;
          w_cap  = ~w_wr;
        end else if (bus.addr_ok) begin
          w_next = S_DATA;
        end else begin
          w_next = S_ADDR;
        end
      end
      S_DATA: begin
        w_stall = w_go;
        if (cancel) begin
          w_next = bus.data_ok ? S_IDLE : S_DRAIN;
        end else if (bus.data_ok) begin
          w_next = S_DONE;
          w_cap  = ~w_wr;
        end
      end
      S_DRAIN: begin
        if (bus.data_ok) w_next = S_IDLE;
      end
      S_DONE: begin
        if (cancel || !longest_stall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) r_rdata <= bus.rdata;
    end
  end

  // reset must silence req/stall without waiting for an edge
  assign bus.req    = w_req & ~rst;
  assign stall      = w_stall & ~rst;
  assign bus.wr     = w_wr;
  assign bus.size   = w_size;
  assign bus.addr   = w_addr;
  assign bus.wdata  = (WRITE_EN != 0) ? sram_wdata : '0;
  assign sram_rdata = r_rdata;

endmodule
